// File: rtl/imu_poll_sequencer.sv
// ---------------------------------------------------------------------------
// imu_poll_sequencer
//
// Drives a byte-level I2C master to bring up an MPU-class IMU (slave 0x68)
// and then poll it.
//
// Bring-up writes, in order:
//   PWR_MGMT_1   (0x6B) <- 0x00
//   GYRO_CONFIG  (0x1B) <- GYRO_CFG
//   ACCEL_CONFIG (0x1C) <- ACCEL_CFG
//
// After bring-up the block waits POLL_DIV cycles between bursts. Each burst
// reads the 14 sensor bytes starting at 0x3B. The seven big-endian words are
// published together, in a single edge, so a consumer never sees a sample
// that mixes two bursts.
//
// Optional build macro IMU_WHOAMI_CHECK_EN:
//   When defined, WHO_AM_I (0x75) is read after bring-up. A value other
//   than 0x68 stops the block with err_code = 2.
//   When undefined, bring-up goes straight to polling and err_code never
//   takes the value 2.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   enable            level-sensitive run request; re-enable restarts bring-up
//   m_cmd_*           command channel to the I2C master (valid/ready)
//   m_rsp_*           one-cycle response pulse from the master (data, nack)
//   accel_*, temp,
//   gyro_*            last published sample
//   sample_valid      one-cycle pulse, asserted in the cycle a sample is published
//   busy              high in every state except IDLE and ERR
//   error, err_code   sticky error: 1 = NACK retries exhausted,
//                     2 = WHO_AM_I mismatch
// ---------------------------------------------------------------------------
module imu_poll_sequencer #(
  parameter int          POLL_DIV  = 10000,
  parameter int          MAX_RETRY = 3,
  parameter logic [7:0]  GYRO_CFG  = 8'h08,
  parameter logic [7:0]  ACCEL_CFG = 8'h10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic               m_cmd_valid,
  input  logic               m_cmd_ready,
  output logic               m_cmd_rw,
  output logic [7:0]         m_cmd_reg,
  output logic [7:0]         m_cmd_wdata,
  input  logic               m_rsp_valid,
  input  logic [7:0]         m_rsp_data,
  input  logic               m_rsp_nack,
  output logic signed [15:0] accel_x,
  output logic signed [15:0] accel_y,
  output logic signed [15:0] accel_z,
  output logic [15:0]        temp,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               sample_valid,
  output logic               busy,
  output logic               error,
  output logic [1:0]         err_code
);

  localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_DIV - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    IDLE,
    INIT_ISSUE,
    INIT_WAIT,
`ifdef IMU_WHOAMI_CHECK_EN
    ID_ISSUE,
    ID_WAIT,
`endif
    POLL_WAIT,
    RD_ISSUE,
    RD_WAIT,
    PUBLISH,
    ERR
  } state_t;

  state_t          state;
  logic [3:0]      idx;      // init step (0..2) or burst byte (0..13)
  logic [RW-1:0]   retry;
  logic [TW-1:0]   timer;
  logic            abort;    // enable dropped while a response was outstanding
  logic [7:0]      shadow [0:12];  // byte 13 goes straight to gyro_z

  // Register address for each bring-up step.
  function automatic logic [7:0] init_reg(input logic [3:0] step);
    case (step)
      4'd0:    init_reg = 8'h6B;
      4'd1:    init_reg = 8'h1B;
      default: init_reg = 8'h1C;
    endcase
  endfunction

  // Write data for each bring-up step.
  function automatic logic [7:0] init_data(input logic [3:0] step);
    case (step)
      4'd0:    init_data = 8'h00;
      4'd1:    init_data = GYRO_CFG;
      default: init_data = ACCEL_CFG;
    endcase
  endfunction

  // After a NACK, the WAIT state returns to the ISSUE state it came from.
  function automatic state_t issue_of(input state_t s);
    case (s)
      INIT_WAIT: issue_of = INIT_ISSUE;
`ifdef IMU_WHOAMI_CHECK_EN
      ID_WAIT:   issue_of = ID_ISSUE;
`endif
      default:   issue_of = RD_ISSUE;
    endcase
  endfunction

  assign busy = (state != IDLE) && (state != ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      retry        <= '0;
      timer        <= '0;
      abort        <= 1'b0;
      m_cmd_valid  <= 1'b0;
      m_cmd_rw     <= 1'b0;
      m_cmd_reg    <= '0;
      m_cmd_wdata  <= '0;
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
      temp         <= '0;
      gyro_x       <= '0;
      gyro_y       <= '0;
      gyro_z       <= '0;
      sample_valid <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= INIT_ISSUE;
            idx         <= '0;
            retry       <= '0;
            abort       <= 1'b0;
            m_cmd_valid <= 1'b1;
            m_cmd_rw    <= 1'b0;
            m_cmd_reg   <= init_reg(4'd0);
            m_cmd_wdata <= init_data(4'd0);
          end
        end

        // m_cmd_valid is always high here; a transfer takes priority over
        // an enable drop so an accepted command is never orphaned.
`ifdef IMU_WHOAMI_CHECK_EN
        INIT_ISSUE, ID_ISSUE, RD_ISSUE: begin
`else
        INIT_ISSUE, RD_ISSUE: begin
`endif
          if (m_cmd_valid && m_cmd_ready) begin
            m_cmd_valid <= 1'b0;
            abort       <= !enable;
            case (state)
              INIT_ISSUE: state <= INIT_WAIT;
`ifdef IMU_WHOAMI_CHECK_EN
              ID_ISSUE:   state <= ID_WAIT;
`endif
              default:    state <= RD_WAIT;
            endcase
          end else if (!enable) begin
            m_cmd_valid <= 1'b0;
            state       <= IDLE;
          end
        end

`ifdef IMU_WHOAMI_CHECK_EN
        INIT_WAIT, ID_WAIT, RD_WAIT: begin
`else
        INIT_WAIT, RD_WAIT: begin
`endif
          if (!enable) abort <= 1'b1;
          if (m_rsp_valid) begin
            if (abort || !enable) begin
              // Outstanding response consumed and discarded.
              state <= IDLE;
              abort <= 1'b0;
              retry <= '0;
            end else if (m_rsp_nack) begin
              if (retry == RETRY_MAX) begin
                state    <= ERR;
                error    <= 1'b1;
                err_code <= 2'd1;
              end else begin
                // Command registers still hold the original command.
                retry       <= retry + 1'b1;
                m_cmd_valid <= 1'b1;
                state       <= issue_of(state);
              end
            end else begin
              retry <= '0;
              case (state)
                INIT_WAIT: begin
                  if (idx == 4'd2) begin
`ifdef IMU_WHOAMI_CHECK_EN
                    state       <= ID_ISSUE;
                    m_cmd_valid <= 1'b1;
                    m_cmd_rw    <= 1'b1;
                    m_cmd_reg   <= 8'h75;
                    m_cmd_wdata <= 8'h00;
`else
                    state <= POLL_WAIT;
                    timer <= '0;
`endif
                  end else begin
                    idx         <= idx + 4'd1;
                    state       <= INIT_ISSUE;
                    m_cmd_valid <= 1'b1;
                    m_cmd_reg   <= init_reg(idx + 4'd1);
                    m_cmd_wdata <= init_data(idx + 4'd1);
                  end
                end
`ifdef IMU_WHOAMI_CHECK_EN
                ID_WAIT: begin
                  if (m_rsp_data != 8'h68) begin
                    state    <= ERR;
                    error    <= 1'b1;
                    err_code <= 2'd2;
                  end else begin
                    state <= POLL_WAIT;
                    timer <= '0;
                  end
                end
`endif
                default: begin
                  if (idx == 4'd13) begin
                    // Publish all seven words together; even byte is high.
                    accel_x      <= {shadow[0],  shadow[1]};
                    accel_y      <= {shadow[2],  shadow[3]};
                    accel_z      <= {shadow[4],  shadow[5]};
                    temp         <= {shadow[6],  shadow[7]};
                    gyro_x       <= {shadow[8],  shadow[9]};
                    gyro_y       <= {shadow[10], shadow[11]};
                    gyro_z       <= {shadow[12], m_rsp_data};
                    sample_valid <= 1'b1;
                    idx          <= '0;
                    state        <= PUBLISH;
                  end else begin
                    shadow[idx] <= m_rsp_data;
                    idx         <= idx + 4'd1;
                    state       <= RD_ISSUE;
                    m_cmd_valid <= 1'b1;
                    m_cmd_reg   <= 8'h3B + {4'h0, idx + 4'd1};
                  end
                end
              endcase
            end
          end
        end

        POLL_WAIT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (timer == TIMER_LAST) begin
            state       <= RD_ISSUE;
            idx         <= '0;
            m_cmd_valid <= 1'b1;
            m_cmd_rw    <= 1'b1;
            m_cmd_reg   <= 8'h3B;
            m_cmd_wdata <= 8'h00;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        PUBLISH: begin
          state <= POLL_WAIT;
          timer <= '0;
        end

        ERR: begin
          m_cmd_valid <= 1'b0;
          error       <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
